// File: rtl/stat_report_pkg.sv
// Shared constants, FSM states and frame builder for stat_report_tx.
// STAT_PARITY_EN adds an even-parity bit sent after the eight data bits.
package stat_report_pkg;

  localparam logic [2:0] SYNC = 3'b101;

`ifdef STAT_PARITY_EN
  localparam int FRAME_W = 9;
`else
  localparam int FRAME_W = 8;
`endif

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;

  // Returns the frame in transmit order: MSB leaves first, parity (if any) last.
  function automatic logic [FRAME_W-1:0] build_frame(input logic [2:0] pend,
                                                     input logic [1:0] lvl);
    logic [7:0] b;
    b = {SYNC, pend, lvl};
`ifdef STAT_PARITY_EN
    return {b, ^b};
`else
    return b;
`endif
  endfunction

endpackage

// File: rtl/stat_edge_latch.sv
// Rising-edge detector with a sticky pending bit; a new edge beats a clear.
module stat_edge_latch (
  input  logic clk_20M,
  input  logic reset_n,
  input  logic din,
  input  logic clr,
  output logic pend
);

  logic prev;

  always_ff @(posedge clk_20M or negedge reset_n) begin
    if (!reset_n) begin
      prev <= 1'b0;
      pend <= 1'b0;
    end else begin
      prev <= din;
      pend <= (din & ~prev) | (pend & ~clr);
    end
  end

endmodule

// File: rtl/stat_report_tx.sv
// Framed 3-wire status transmitter: event frames plus a periodic heartbeat.
// Build with STAT_PARITY_EN defined for a 9-bit frame carrying even parity.
module stat_report_tx
  import stat_report_pkg::*;
#(
  parameter int CLK_DIV   = 10,
  parameter int HEARTBEAT = 20000,
  parameter int GAP_BITS  = 2
) (
  input  logic clk_20M,
  input  logic reset_n,
  input  logic dsp_err,
  input  logic optolock,
  input  logic fastlock,
  output logic tx_sclk,
  output logic tx_frame,
  output logic tx_sdata,
  output logic busy
);

  localparam int NUM_IN = 3;

  logic [NUM_IN-1:0]  din, pend;
  state_t             state, state_nxt;
  logic               go, load, seg_end, half_end, bit_end, ph, hb_req;
  logic [7:0]         div;
  logic [3:0]         bit_cnt;
  logic [23:0]        hb_cnt;
  logic [FRAME_W-1:0] sh;

  assign din = {dsp_err, optolock, fastlock};

  for (genvar i = 0; i < NUM_IN; i++) begin : g_lat
    stat_edge_latch u_lat (
      .clk_20M (clk_20M),
      .reset_n (reset_n),
      .din     (din[i]),
      .clr     (load),
      .pend    (pend[i])
    );
  end

  assign half_end = (div == 8'(CLK_DIV - 1));
  assign bit_end  = half_end & ph;

  always_ff @(posedge clk_20M or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    go        = 1'b0;
    load      = 1'b0;
    seg_end   = 1'b0;
    case (state)
      IDLE:  if ((|pend) || hb_req) begin
               go        = 1'b1;
               state_nxt = LOAD;
             end
      LOAD:  begin
               load      = 1'b1;
               state_nxt = SHIFT;
             end
      SHIFT: if (bit_end && bit_cnt == 4'(FRAME_W - 1)) begin
               seg_end   = 1'b1;
               state_nxt = GAP;
             end
      GAP:   if (bit_end && bit_cnt == 4'(GAP_BITS - 1)) begin
               seg_end   = 1'b1;
               state_nxt = IDLE;
             end
      default: state_nxt = IDLE;
    endcase
  end

  // Cleared on entry to LOAD so LOAD-to-LOAD heartbeat spacing is exactly HEARTBEAT.
  always_ff @(posedge clk_20M or negedge reset_n) begin
    if (!reset_n) begin
      hb_cnt <= '0;
      hb_req <= 1'b0;
    end else if (go) begin
      hb_cnt <= '0;
      hb_req <= 1'b0;
    end else begin
      hb_cnt <= (hb_cnt == 24'(HEARTBEAT - 1)) ? '0 : hb_cnt + 24'd1;
      if (hb_cnt == 24'(HEARTBEAT - 2)) hb_req <= 1'b1;
    end
  end

  // ph is the half-period phase; in GAP it paces the idle bits without driving tx_sclk.
  always_ff @(posedge clk_20M or negedge reset_n) begin
    if (!reset_n) begin
      sh       <= '0;
      tx_frame <= 1'b0;
      div      <= '0;
      ph       <= 1'b0;
      bit_cnt  <= '0;
    end else begin
      case (state)
        LOAD: begin
          sh       <= build_frame(pend, {optolock, fastlock});
          tx_frame <= 1'b1;
          div      <= '0;
          ph       <= 1'b0;
          bit_cnt  <= '0;
        end
        SHIFT, GAP: begin
          if (half_end) begin
            div <= '0;
            ph  <= ~ph;
            if (ph) begin
              if (seg_end) begin
                bit_cnt  <= '0;
                tx_frame <= 1'b0;
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
                sh      <= {sh[FRAME_W-2:0], 1'b0};
              end
            end
          end else begin
            div <= div + 8'd1;
          end
        end
        default: begin
          div     <= '0;
          ph      <= 1'b0;
          bit_cnt <= '0;
        end
      endcase
    end
  end

  assign tx_sclk  = ph & (state == SHIFT);
  assign tx_sdata = tx_frame & sh[FRAME_W-1];
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_stat_report_tx.sv
// Scoreboard bench for stat_report_tx: one DUT for event frames, one with a short heartbeat.
`timescale 1ns/1ps
module tb_stat_report_tx;

  localparam int CLK_DIV  = 10;
  localparam int GAP_BITS = 2;
  localparam int FW       = stat_report_pkg::FRAME_W;
  localparam int FLEN     = FW * 2 * CLK_DIV;
  localparam int GLEN     = GAP_BITS * 2 * CLK_DIV;

  logic clk_20M = 1'b0;
  logic reset_n = 1'b0;
  logic hb_rst_n = 1'b0;
  logic dsp_err = 1'b0, optolock = 1'b0, fastlock = 1'b0;
  logic [1:0] sclk, frame, sdata, busy;

  stat_report_tx #(.CLK_DIV(CLK_DIV), .HEARTBEAT(20000), .GAP_BITS(GAP_BITS)) dut (
    .clk_20M (clk_20M), .reset_n (reset_n),
    .dsp_err (dsp_err), .optolock (optolock), .fastlock (fastlock),
    .tx_sclk (sclk[0]), .tx_frame (frame[0]), .tx_sdata (sdata[0]), .busy (busy[0])
  );

  stat_report_tx #(.CLK_DIV(CLK_DIV), .HEARTBEAT(500), .GAP_BITS(GAP_BITS)) dut_hb (
    .clk_20M (clk_20M), .reset_n (hb_rst_n),
    .dsp_err (1'b0), .optolock (1'b1), .fastlock (1'b1),
    .tx_sclk (sclk[1]), .tx_frame (frame[1]), .tx_sdata (sdata[1]), .busy (busy[1])
  );

  always #25 clk_20M = ~clk_20M;

  int cyc = 0;
  always @(posedge clk_20M) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] word;
    int          nbits;
    int          flen;
    int          ld;
  } rx_t;

  rx_t         rx_q[$];
  rx_t         hb_q[$];
  logic [15:0] exp_q[$];

  int checks = 0;
  int failures = 0;

  // Frame decoder for both DUTs, sampled on the falling clock edge.
  logic [1:0]  p_sclk = '0, p_frame = '0, p_sdata = '0, p_busy = '0;
  logic [15:0] sh[2] = '{16'd0, 16'd0};
  int nb[2] = '{0, 0};
  int fl[2] = '{0, 0};
  int ld[2] = '{0, 0};
  int bl[2] = '{0, 0};
  int last_bl[2] = '{0, 0};
  int glitch[2] = '{0, 0};

  always @(negedge clk_20M) begin
    for (int m = 0; m < 2; m++) begin
      if (busy[m] && !p_busy[m]) begin
        ld[m] <= cyc;
        bl[m] <= 1;
      end else if (busy[m]) begin
        bl[m] <= bl[m] + 1;
      end
      if (!busy[m] && p_busy[m]) last_bl[m] <= bl[m];
      if (frame[m]) begin
        fl[m] <= fl[m] + 1;
        if (sclk[m] && !p_sclk[m]) begin
          sh[m] <= {sh[m][14:0], sdata[m]};
          nb[m] <= nb[m] + 1;
        end
        if (sclk[m] && p_sclk[m] && sdata[m] !== p_sdata[m]) glitch[m] <= glitch[m] + 1;
      end else if (p_frame[m]) begin
        if (m == 0) rx_q.push_back(rx_t'{sh[m], nb[m], fl[m], ld[m]});
        else        hb_q.push_back(rx_t'{sh[m], nb[m], fl[m], ld[m]});
        sh[m] <= '0;
        nb[m] <= 0;
        fl[m] <= 0;
      end
    end
    p_sclk  <= sclk;
    p_frame <= frame;
    p_sdata <= sdata;
    p_busy  <= busy;
  end

  function automatic logic [15:0] exp_word(input logic [7:0] b);
`ifdef STAT_PARITY_EN
    return {7'd0, b, ^b};
`else
    return {8'd0, b};
`endif
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk_20M);
    #1;
  endtask

  task automatic wait_rx(input int n, input int lim, output bit ok);
    int i;
    ok = 1'b0;
    i  = 0;
    while (i < lim && !ok) begin
      if (rx_q.size() >= n) ok = 1'b1;
      else begin
        @(posedge clk_20M);
        i++;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    dsp_err  = 1'b0;
    optolock = 1'b0;
    fastlock = 1'b0;
    tick(3);
    reset_n = 1'b1;
    tick(2);
    rx_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    tick(3);
    checks += 4;
    if (sclk[0]  !== 1'b0) begin failures++; $display("FAIL reset_sclk got=%b want=0", sclk[0]); end
    if (frame[0] !== 1'b0) begin failures++; $display("FAIL reset_frame got=%b want=0", frame[0]); end
    if (sdata[0] !== 1'b0) begin failures++; $display("FAIL reset_sdata got=%b want=0", sdata[0]); end
    if (busy[0]  !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy[0]); end
    do_reset();
  endtask

  task automatic test_opto();
    rx_t r; logic [15:0] e; bit ok; int g0; int k;
    do_reset();
    g0 = glitch[0];
    optolock = 1'b1;
    exp_q.push_back(exp_word(8'hAA));
    wait_rx(1, 600, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL opto_timeout got=none want=frame"); end
    else begin
      r = rx_q.pop_front();
      e = exp_q.pop_front();
      checks += 3;
      if (r.word !== e)     begin failures++; $display("FAIL opto_word got=%h want=%h", r.word, e); end
      if (r.nbits !== FW)   begin failures++; $display("FAIL opto_nbits got=%0d want=%0d", r.nbits, FW); end
      if (r.flen !== FLEN)  begin failures++; $display("FAIL opto_frame_len got=%0d want=%0d", r.flen, FLEN); end
      k = 0;
      while (busy[0] && k < 200) begin tick(1); k++; end
      @(negedge clk_20M); #1;
      checks++;
      if (last_bl[0] - r.flen - 1 !== GLEN)
        begin failures++; $display("FAIL opto_gap_len got=%0d want=%0d", last_bl[0] - r.flen - 1, GLEN); end
    end
    checks++;
    if (glitch[0] - g0 !== 0) begin failures++; $display("FAIL opto_sdata_stable got=%0d want=0", glitch[0] - g0); end
    optolock = 1'b0;
  endtask

  task automatic test_dsp_latency();
    rx_t r; logic [15:0] e; bit ok; int g0;
    do_reset();
    g0 = glitch[0];
    dsp_err = 1'b1;
    exp_q.push_back(exp_word(8'hB0));
    tick(1);
    dsp_err = 1'b0;
    checks++;
    if (busy[0] !== 1'b0) begin failures++; $display("FAIL lat_busy_n1 got=%b want=0", busy[0]); end
    tick(1);
    checks += 2;
    if (busy[0]  !== 1'b1) begin failures++; $display("FAIL lat_busy_load got=%b want=1", busy[0]); end
    if (frame[0] !== 1'b0) begin failures++; $display("FAIL lat_frame_load got=%b want=0", frame[0]); end
    tick(1);
    checks += 2;
    if (frame[0] !== 1'b1) begin failures++; $display("FAIL lat_frame_n3 got=%b want=1", frame[0]); end
    if (sdata[0] !== 1'b1) begin failures++; $display("FAIL lat_msb_n3 got=%b want=1", sdata[0]); end
    wait_rx(1, 600, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL dsp_timeout got=none want=frame"); end
    else begin
      r = rx_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (r.word !== e) begin failures++; $display("FAIL dsp_word got=%h want=%h", r.word, e); end
    end
    checks++;
    if (glitch[0] - g0 !== 0) begin failures++; $display("FAIL dsp_sdata_stable got=%0d want=0", glitch[0] - g0); end
  endtask

  task automatic test_load_edge();
    rx_t r0, r1; logic [15:0] e; bit ok;
    do_reset();
    dsp_err = 1'b1;
    exp_q.push_back(exp_word(8'hB0));
    tick(1);
    dsp_err = 1'b0;
    tick(1);
    dsp_err = 1'b1;
    exp_q.push_back(exp_word(8'hB0));
    tick(1);
    dsp_err = 1'b0;
    wait_rx(2, 1200, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL load_edge_timeout got=%0d want=2 frames", rx_q.size()); end
    else begin
      r0 = rx_q.pop_front();
      r1 = rx_q.pop_front();
      checks += 3;
      e = exp_q.pop_front();
      if (r0.word !== e) begin failures++; $display("FAIL load_edge_word0 got=%h want=%h", r0.word, e); end
      e = exp_q.pop_front();
      if (r1.word !== e) begin failures++; $display("FAIL load_edge_word1 got=%h want=%h", r1.word, e); end
      if (r1.ld - r0.ld < 1 + FLEN + GLEN)
        begin failures++; $display("FAIL load_edge_spacing got=%0d want>=%0d", r1.ld - r0.ld, 1 + FLEN + GLEN); end
    end
  endtask

  task automatic test_shift_edge();
    rx_t r; logic [15:0] e; bit ok;
    do_reset();
    dsp_err = 1'b1;
    exp_q.push_back(exp_word(8'hB0));
    tick(1);
    dsp_err = 1'b0;
    tick(60);
    fastlock = 1'b1;
    exp_q.push_back(exp_word(8'hA5));
    wait_rx(2, 1200, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL shift_edge_timeout got=%0d want=2 frames", rx_q.size()); end
    else begin
      for (int i = 0; i < 2; i++) begin
        r = rx_q.pop_front();
        e = exp_q.pop_front();
        checks++;
        if (r.word !== e) begin failures++; $display("FAIL shift_edge_word%0d got=%h want=%h", i, r.word, e); end
      end
    end
    fastlock = 1'b0;
  endtask

  task automatic test_reset_mid();
    rx_t r; logic [15:0] e; bit ok;
    do_reset();
    dsp_err = 1'b1;
    tick(1);
    dsp_err = 1'b0;
    tick(4);
    fastlock = 1'b1;
    tick(1);
    fastlock = 1'b0;
    tick(8);
    @(posedge clk_20M);
    #6;
    checks++;
    if (sclk[0] !== 1'b1) begin failures++; $display("FAIL mid_sclk_high got=%b want=1", sclk[0]); end
    #1 reset_n = 1'b0;
    #1;
    checks += 4;
    if (sclk[0]  !== 1'b0) begin failures++; $display("FAIL mid_rst_sclk got=%b want=0", sclk[0]); end
    if (frame[0] !== 1'b0) begin failures++; $display("FAIL mid_rst_frame got=%b want=0", frame[0]); end
    if (sdata[0] !== 1'b0) begin failures++; $display("FAIL mid_rst_sdata got=%b want=0", sdata[0]); end
    if (busy[0]  !== 1'b0) begin failures++; $display("FAIL mid_rst_busy got=%b want=0", busy[0]); end
    tick(2);
    reset_n = 1'b1;
    tick(2);
    rx_q.delete();
    tick(400);
    checks++;
    if (rx_q.size() !== 0) begin failures++; $display("FAIL mid_rst_no_frame got=%0d want=0", rx_q.size()); end
    dsp_err = 1'b1;
    exp_q.push_back(exp_word(8'hB0));
    tick(1);
    dsp_err = 1'b0;
    wait_rx(1, 600, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL mid_rst_timeout got=none want=frame"); end
    else begin
      r = rx_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (r.word !== e) begin failures++; $display("FAIL mid_rst_word got=%h want=%h", r.word, e); end
    end
  endtask

  task automatic test_heartbeat();
    rx_t f[3]; logic [15:0] e; int k;
    exp_q.delete();
    tick(1);
    hb_rst_n = 1'b1;
    hb_q.delete();
    exp_q.push_back(exp_word(8'hAF));
    exp_q.push_back(exp_word(8'hA3));
    exp_q.push_back(exp_word(8'hA3));
    k = 0;
    while (hb_q.size() < 3 && k < 2000) begin tick(1); k++; end
    checks++;
    if (hb_q.size() < 3) begin failures++; $display("FAIL hb_timeout got=%0d want=3 frames", hb_q.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        f[i] = hb_q.pop_front();
        e = exp_q.pop_front();
        checks++;
        if (f[i].word !== e) begin failures++; $display("FAIL hb_word%0d got=%h want=%h", i, f[i].word, e); end
      end
      checks += 2;
      if (f[1].ld - f[0].ld !== 500) begin failures++; $display("FAIL hb_spacing0 got=%0d want=500", f[1].ld - f[0].ld); end
      if (f[2].ld - f[1].ld !== 500) begin failures++; $display("FAIL hb_spacing1 got=%0d want=500", f[2].ld - f[1].ld); end
    end
  endtask

  initial begin
    test_reset();
    test_opto();
    test_dsp_latency();
    test_load_edge();
    test_shift_edge();
    test_reset_mid();
    test_heartbeat();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stat_report_tx.md
# stat_report_tx

Serial status transmitter from the FPGA to the DSP. It edge-detects the board status inputs `dsp_err`, `optolock` and `fastlock` and latches each event as pending. It sends the pending events and the current lock levels as a framed, clocked serial word on a 3-wire link. A frame is sent whenever an event is pending, and also periodically as a heartbeat. The block sits next to the front-panel LED latch logic on the same status inputs, in the `clk_20M` domain.

## Interface
- `CLK_DIV`, 10: `clk_20M` cycles per `tx_sclk` half-period (range 1..255); default gives a 1 MHz `tx_sclk`.
- `HEARTBEAT`, 20000: `clk_20M` cycles between heartbeat frames (1 ms); range 2..2^24-1.
- `GAP_BITS`, 2: idle bit periods with `tx_frame` low after each frame (range 1..15).

Ports:
- `clk_20M` in 1: the only clock, 20 MHz.
- `reset_n` in 1: asynchronous active-low reset.
- `dsp_err` in 1: DSP error status; synchronous to `clk_20M`.
- `optolock` in 1: optical lock status; synchronous.
- `fastlock` in 1: fast-loop lock status; synchronous.
- `tx_sclk` out 1: serial clock to the DSP; idles low.
- `tx_frame` out 1: high for the whole frame.
- `tx_sdata` out 1: serial data, MSB first.
- `busy` out 1: high from the load cycle to the end of the gap.

## Operation
- Edge capture: each input is registered, and a rising edge (prev=0, cur=1) sets that input's pending bit.
- Pending bits clear on the LOAD cycle, when they are copied into the frame.
  - An edge in the same cycle as LOAD re-sets the bit, so set wins and the event goes into the next frame.
- Frame word, 8 bits: [7:5]=3'b101 sync, [4]=dsp_err pending, [3]=optolock pending, [2]=fastlock pending, [1]=optolock level, [0]=fastlock level.
  - Both levels are sampled at LOAD.
- Heartbeat counter:
  - Free-running 0..HEARTBEAT-1.
  - Reaching HEARTBEAT-1 sets `hb_req`.
  - Both the counter and `hb_req` reset on LOAD.
- FSM states: IDLE, LOAD, SHIFT, GAP.
  - IDLE -> LOAD when any pending bit or `hb_req` is set.
  - LOAD (1 cycle): snapshot into the shift register, clear pending, set `tx_frame`, present the MSB -> SHIFT.
  - SHIFT: for each bit, `tx_sclk` is low for CLK_DIV cycles, then high for CLK_DIV cycles. `tx_sdata` changes only while `tx_sclk` is low; the DSP samples on the rising edge. After the last bit -> GAP.
  - GAP: `tx_frame`=0, `tx_sdata`=0, `tx_sclk`=0 for GAP_BITS*2*CLK_DIV cycles -> IDLE.
- Events during SHIFT or GAP stay pending; they are never lost or merged into the current frame.
- Bit counter width is 4 bits and the divider counter width is 8 bits; neither wraps within its legal range.

## Timing
- Reset values: `tx_sclk`=0, `tx_frame`=0, `tx_sdata`=0, `busy`=0. Pending bits, `hb_req`, the counters and the FSM (IDLE) are also cleared.
- Reset asserted mid-frame aborts the frame immediately and discards pending events.
- Latency from an input rising edge (cycle N, sampled at edge N+1):
  - pending set at N+1;
  - LOAD at N+2;
  - `tx_frame`=1 and MSB on `tx_sdata` registered at the end of LOAD, visible from N+3.
- Frame duration: FRAME_W*2*CLK_DIV cycles (160 at the defaults, no parity).
- Back-to-back frames are always separated by the GAP.
- Simultaneous heartbeat expiry and event: a single frame carries the event and also satisfies the heartbeat.

## Configuration
- `STAT_PARITY_EN` defined: FRAME_W=9. Bit 8 is sent last and equals the XOR of frame bits [7:0] (even parity).
- Not defined: FRAME_W=8 with no parity bit.

## Structure
- Package `stat_report_pkg`: SYNC constant 3'b101, FRAME_W (depends on `STAT_PARITY_EN`), state enum (IDLE/LOAD/SHIFT/GAP).
- Sub-module `stat_edge_latch` (edge detect plus pending set/clear with set priority), instantiated three times.

## Test plan
- Reset, then optolock rises and stays high, CLK_DIV=10: frame 0xAA. `tx_frame` high 160 cycles, then low 40 cycles. With parity, bit 8 = 0.
- dsp_err 1-cycle pulse, locks low: frame 0xB0. With parity, bit 8 = 1. `tx_sdata` stable while `tx_sclk` is high.
- No events, optolock=fastlock=1, HEARTBEAT=500: frame 0xA3 every 500 cycles. Start spacing is measured from LOAD to LOAD.
- fastlock edge during SHIFT of a dsp_err frame: current frame 0xB0 (fastlock level sampled at LOAD), next frame 0xA5 after the gap.
- Event edge in exactly the LOAD cycle: absent from the current frame, present in the following frame.
- `reset_n` low mid-SHIFT: all outputs 0 asynchronously, `busy`=0; no frame after release until a new event or heartbeat.
